// File: rtl/regfile_mp.sv
// Two-write / two-read register file with a sequenced clear (one entry per cycle).
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd1,
    input  logic [DATA_W-1:0] wd2,
    input  logic              we1,
    input  logic              we2,
    input  logic              clr,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam bit ZR = (ZERO_REG != 0);

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;

    logic              wen1, wen2;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                if (clr) begin
                    ptr_next = '0;
                end else begin
                    ptr_next = ptr + ADDR_W'(1);
                    if (ptr == LAST) state_next = IDLE;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // The sequencer borrows write port 1 while clearing; user writes only land in IDLE.
    always_comb begin
        wen1   = 1'b0;
        wen2   = 1'b0;
        waddr1 = wa1;
        wdata1 = wd1;
        if (!rst) begin
            if (state == CLEAR) begin
                wen1   = 1'b1;
                waddr1 = ptr;
                wdata1 = '0;
            end else begin
                wen1 = we1 && !(ZR && wa1 == '0);
                wen2 = we2 && !(ZR && wa2 == '0);
            end
        end
    end

    // No reset on the array so it can map onto RAM; port 2 is assigned last and wins collisions.
    always_ff @(posedge clk) begin
        if (wen1) mem[waddr1] <= wdata1;
        if (wen2) mem[wa2]    <= wd2;
    end

    assign raddr[0] = ra1;
    assign raddr[1] = ra2;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rdata[i] = mem[raddr[i]];
            if (BYPASS && !rst && wen1 && wa1 == raddr[i]) rdata[i] = wd1;
            if (BYPASS && !rst && wen2 && wa2 == raddr[i]) rdata[i] = wd2;
            if (ZR && raddr[i] == '0) rdata[i] = '0;
            if (state == CLEAR) rdata[i] = '0;
        end
    end

    assign rd1  = rdata[0];
    assign rd2  = rdata[1];
    assign busy = (state == CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp: one instance with ZERO_REG=0 and one with ZERO_REG=1,
// both compared every cycle against an array-based reference model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, we1, we2, clr;
    logic [AW-1:0] ra1, ra2, wa1, wa2;
    logic [DW-1:0] wd1, wd2;
    logic [DW-1:0] rd1, rd2, rd1z, rd2z;
    logic          busy, busyz;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m0 [DEPTH];
    logic [DW-1:0] mz [DEPTH];
    int            clr_left = 0;
    bit            model_valid = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2), .we1(we1), .we2(we2),
        .clr(clr), .busy(busy)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dutz (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1z), .rd2(rd2z),
        .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2), .we1(we1), .we2(we2),
        .clr(clr), .busy(busyz)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observable behaviour: while clearing every read is 0, so the model zeroes the whole array at once.
    function automatic logic [DW-1:0] expRead(input bit z, input logic [AW-1:0] a);
        if (clr_left > 0) return '0;
        if (z && a == 0) return '0;
        if (BYPASS && !rst && we2 && wa2 == a) return wd2;
        if (BYPASS && !rst && we1 && wa1 == a) return wd1;
        return z ? mz[a] : m0[a];
    endfunction

    task automatic verifyModel();
        if (!model_valid) return;
        checkOutput("rd1", rd1, expRead(0, ra1));
        checkOutput("rd2", rd2, expRead(0, ra2));
        checkOutput("busy", {31'b0, busy}, {31'b0, clr_left > 0});
        checkOutput("z_rd1", rd1z, expRead(1, ra1));
        checkOutput("z_rd2", rd2z, expRead(1, ra2));
        checkOutput("z_busy", {31'b0, busyz}, {31'b0, clr_left > 0});
    endtask

    task automatic applyStimulus(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                 input logic [AW-1:0] w1, input logic [AW-1:0] w2,
                                 input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                 input logic e1, input logic e2, input logic c, input logic r);
        @(negedge clk);
        ra1 = a1; ra2 = a2; wa1 = w1; wa2 = w2;
        wd1 = d1; wd2 = d2; we1 = e1; we2 = e2; clr = c; rst = r;
        #1;
        verifyModel();
    endtask

    task automatic clockEdge();
        @(posedge clk);
        if (rst) begin
            clr_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin m0[i] = '0; mz[i] = '0; end
            model_valid = 1;
        end else if (clr_left > 0) begin
            clr_left = clr ? DEPTH : clr_left - 1;
        end else begin
            if (we1) begin m0[wa1] = wd1; if (wa1 != 0) mz[wa1] = wd1; end
            if (we2) begin m0[wa2] = wd2; if (wa2 != 0) mz[wa2] = wd2; end
            if (clr) begin
                clr_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) begin m0[i] = '0; mz[i] = '0; end
            end
        end
    endtask

    task automatic idleRead(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        applyStimulus(a1, a2, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        bit b;
        logic [AW-1:0] a;

        // Reset and measure busy length.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        clockEdge();
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            idleRead(AW'(i), AW'(i));
            b = busy;
            clockEdge();
            if (!b) break;
            cnt++;
        end
        checkOutput("rst_busy_len", cnt, 64);
        for (int i = 0; i < DEPTH; i++) begin
            idleRead(AW'(i), AW'(63 - i));
            checkOutput("rst_rd1_zero", rd1, 0);
            checkOutput("rst_rd2_zero", rd2, 0);
            clockEdge();
        end

        // Basic write then read on both ports.
        applyStimulus(0, 0, 5, 0, 32'hDEADBEEF, 0, 1, 0, 0, 0);
        clockEdge();
        idleRead(5, 5);
        checkOutput("wr_rd1", rd1, 32'hDEADBEEF);
        checkOutput("wr_rd2", rd2, 32'hDEADBEEF);
        clockEdge();

        // Same-address collision: port 2 wins.
        applyStimulus(0, 0, 9, 9, 32'h1111, 32'h2222, 1, 1, 0, 0);
        clockEdge();
        idleRead(9, 9);
        checkOutput("collision", rd1, 32'h2222);
        clockEdge();

        // Same-cycle read of a location being written.
        applyStimulus(12, 0, 12, 0, 32'h77, 0, 1, 0, 0, 0);
        checkOutput("bypass_rd1", rd1, BYPASS ? 32'h77 : 32'h0);
        clockEdge();
        idleRead(12, 12);
        checkOutput("after_wr_12", rd1, 32'h77);
        clockEdge();

        // Entry 0 on the ZERO_REG instance is hardwired.
        applyStimulus(0, 0, 0, 0, 32'hFFFF, 0, 1, 0, 0, 0);
        checkOutput("zero_same_cycle", rd1z, 0);
        clockEdge();
        idleRead(0, 0);
        checkOutput("zero_next_cycle", rd1z, 0);
        checkOutput("nonzero_reg0", rd1, 32'hFFFF);
        clockEdge();

        // Fill, clear with writes attempted during busy, re-pulse clr on the 30th busy cycle.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 0, AW'(i), 0, 32'hA5A5A5A5, 0, 1, 0, 0, 0);
            clockEdge();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        clockEdge();
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            a = AW'($urandom_range(0, DEPTH - 1));
            applyStimulus(a, a, a, AW'($urandom), $urandom, $urandom,
                          clr_left > 0, clr_left > 0, cnt == 29, 0);
            b = busy;
            clockEdge();
            if (!b) break;
            cnt++;
        end
        checkOutput("clr_busy_len", cnt, 94);
        for (int i = 0; i < DEPTH; i++) begin
            idleRead(AW'(i), AW'(i));
            checkOutput("clr_rd_zero", rd1, 0);
            clockEdge();
        end

        // Random traffic over a narrow address window to provoke collisions.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                          $urandom, $urandom,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
            clockEdge();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
